// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Round-robin read arbiter: IF and MEM share a single-outstanding AXI read channel.
// An IF response can be dropped by if_flush while IF owns the bus.
module ysyx_22041071_axi_rd_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RESP_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_ar_valid,
  input  logic [ADDR_W-1:0] if_ar_addr,
  output logic              if_ar_ready,
  input  logic              if_flush,
  output logic              if_r_valid,
  output logic [DATA_W-1:0] if_r_data,
  output logic [ADDR_W-1:0] if_r_addr,
  output logic [RESP_W-1:0] if_r_resp,
  input  logic              mem_ar_valid,
  input  logic [ADDR_W-1:0] mem_ar_addr,
  output logic              mem_ar_ready,
  output logic              mem_r_valid,
  output logic [DATA_W-1:0] mem_r_data,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [RESP_W-1:0] mem_r_resp,
  output logic              m_ar_valid,
  output logic [ADDR_W-1:0] m_ar_addr,
  input  logic              m_ar_ready,
  input  logic              m_r_valid,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [RESP_W-1:0] m_r_resp,
  output logic              m_r_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e              state_q;
  logic                owner_mem_q;
  logic                prio_mem_q;
  logic                drop_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                if_r_valid_q, mem_r_valid_q;
  logic [DATA_W-1:0]   if_r_data_q, mem_r_data_q;
  logic [ADDR_W-1:0]   if_r_addr_q, mem_r_addr_q;
  logic [RESP_W-1:0]   if_r_resp_q, mem_r_resp_q;

  logic                grant_mem, grant_if, in_idle;
  logic [ADDR_W-1:0]   addr_d;

  // MEM wins a tie only when the pointer favours it; a lone requester always wins.
  assign grant_mem = mem_ar_valid && (!if_ar_valid || prio_mem_q);
  assign grant_if  = if_ar_valid && !grant_mem;
  assign addr_d    = grant_mem ? mem_ar_addr : if_ar_addr;
  assign in_idle   = (state_q == S_IDLE) && !reset;

  assign if_ar_ready  = in_idle && grant_if;
  assign mem_ar_ready = in_idle && grant_mem;
  assign m_ar_valid   = (state_q == S_ADDR);
  assign m_ar_addr    = addr_q;
  assign m_r_ready    = (state_q == S_DATA);

  assign if_r_valid  = if_r_valid_q;
  assign if_r_data   = if_r_data_q;
  assign if_r_addr   = if_r_addr_q;
  assign if_r_resp   = if_r_resp_q;
  assign mem_r_valid = mem_r_valid_q;
  assign mem_r_data  = mem_r_data_q;
  assign mem_r_addr  = mem_r_addr_q;
  assign mem_r_resp  = mem_r_resp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_mem_q   <= 1'b0;
      prio_mem_q    <= 1'b1;
      drop_q        <= 1'b0;
      addr_q        <= '0;
      if_r_valid_q  <= 1'b0;
      mem_r_valid_q <= 1'b0;
      if_r_data_q   <= '0;
      if_r_addr_q   <= '0;
      if_r_resp_q   <= '0;
      mem_r_data_q  <= '0;
      mem_r_addr_q  <= '0;
      mem_r_resp_q  <= '0;
    end else begin
      if_r_valid_q  <= 1'b0;
      mem_r_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          drop_q <= 1'b0;
          if (if_ar_valid || mem_ar_valid) begin
            addr_q      <= addr_d;
            owner_mem_q <= grant_mem;
            prio_mem_q  <= !grant_mem;
            state_q     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!owner_mem_q && if_flush) drop_q <= 1'b1;
          if (m_ar_ready) state_q <= S_DATA;
        end
        S_DATA: begin
          if (!owner_mem_q && if_flush) drop_q <= 1'b1;
          if (m_r_valid) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            if (owner_mem_q) begin
              mem_r_valid_q <= 1'b1;
              mem_r_data_q  <= m_r_data;
              mem_r_addr_q  <= addr_q;
              mem_r_resp_q  <= m_r_resp;
            end else if (!drop_q && !if_flush) begin
              // A flush arriving with the beat itself also suppresses delivery.
              if_r_valid_q <= 1'b1;
              if_r_data_q  <= m_r_data;
              if_r_addr_q  <= addr_q;
              if_r_resp_q  <= m_r_resp;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Bench for the AXI read arbiter: transaction-timing model plus directed literal pins.
module tb_ysyx_22041071_axi_rd_arb;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_ar_valid, if_ar_ready, if_flush, if_r_valid;
  logic [AW-1:0] if_ar_addr, if_r_addr;
  logic [DW-1:0] if_r_data;
  logic [RW-1:0] if_r_resp;
  logic          mem_ar_valid, mem_ar_ready, mem_r_valid;
  logic [AW-1:0] mem_ar_addr, mem_r_addr;
  logic [DW-1:0] mem_r_data;
  logic [RW-1:0] mem_r_resp;
  logic          m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [AW-1:0] m_ar_addr;
  logic [DW-1:0] m_r_data;
  logic [RW-1:0] m_r_resp;

  ysyx_22041071_axi_rd_arb #(.ADDR_W(AW), .DATA_W(DW), .RESP_W(RW)) dut (
    .clk(clk), .reset(reset),
    .if_ar_valid(if_ar_valid), .if_ar_addr(if_ar_addr), .if_ar_ready(if_ar_ready),
    .if_flush(if_flush), .if_r_valid(if_r_valid), .if_r_data(if_r_data),
    .if_r_addr(if_r_addr), .if_r_resp(if_r_resp),
    .mem_ar_valid(mem_ar_valid), .mem_ar_addr(mem_ar_addr), .mem_ar_ready(mem_ar_ready),
    .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .mem_r_addr(mem_r_addr),
    .mem_r_resp(mem_r_resp),
    .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_ready(m_ar_ready),
    .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_ready(m_r_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic          exp_if_rdy, exp_mem_rdy, exp_arv, exp_rrdy, exp_if_rv, exp_mem_rv;
  logic [AW-1:0] exp_araddr, exp_if_raddr, exp_mem_raddr;
  logic [DW-1:0] exp_if_data, exp_mem_data;
  logic [RW-1:0] exp_if_resp, exp_mem_resp;

  // Transaction-level model state
  bit            busy, own_mem, dropped, ptr_mem, clr_if, clr_mem, win_mem;
  int            c = 0, t_g, t_end, aw, rw;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] pl_data;
  logic [RW-1:0] pl_resp;

  // Directed-mode controls
  bit            rnd, d_flush, d_if_new, d_mem_new;
  int            d_a, d_r;
  logic [AW-1:0] d_if_addr, d_mem_addr;
  logic [DW-1:0] d_data;
  logic [RW-1:0] d_resp;

  bit            pin_en [3];
  int            pin_sel [3];
  logic [63:0]   pin_val [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] pin_act(input int s);
    case (s)
      0:  return 64'(if_ar_ready);
      1:  return 64'(mem_ar_ready);
      2:  return 64'(m_ar_valid);
      3:  return m_ar_addr;
      4:  return 64'(m_r_ready);
      5:  return 64'(if_r_valid);
      6:  return if_r_data;
      7:  return if_r_addr;
      8:  return 64'(mem_r_valid);
      9:  return 64'(mem_r_resp);
      default: return 64'hdead;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_ar_ready", 64'(if_ar_ready), 64'(exp_if_rdy));
      chk("mem_ar_ready", 64'(mem_ar_ready), 64'(exp_mem_rdy));
      chk("m_ar_valid", 64'(m_ar_valid), 64'(exp_arv));
      if (exp_arv) chk("m_ar_addr", m_ar_addr, exp_araddr);
      chk("m_r_ready", 64'(m_r_ready), 64'(exp_rrdy));
      chk("if_r_valid", 64'(if_r_valid), 64'(exp_if_rv));
      chk("mem_r_valid", 64'(mem_r_valid), 64'(exp_mem_rv));
      chk("if_r_data", if_r_data, exp_if_data);
      chk("if_r_addr", if_r_addr, exp_if_raddr);
      chk("if_r_resp", 64'(if_r_resp), 64'(exp_if_resp));
      chk("mem_r_data", mem_r_data, exp_mem_data);
      chk("mem_r_addr", mem_r_addr, exp_mem_raddr);
      chk("mem_r_resp", 64'(mem_r_resp), 64'(exp_mem_resp));
      for (int k = 0; k < 3; k++)
        if (pin_en[k]) chk($sformatf("pin%0d", pin_sel[k]), pin_act(pin_sel[k]), pin_val[k]);
    end
  end

  task automatic model_zero();
    exp_if_rdy = 0; exp_mem_rdy = 0; exp_arv = 0; exp_rrdy = 0; exp_if_rv = 0; exp_mem_rv = 0;
    exp_araddr = '0; exp_if_raddr = '0; exp_mem_raddr = '0;
    exp_if_data = '0; exp_mem_data = '0; exp_if_resp = '0; exp_mem_resp = '0;
    busy = 0; ptr_mem = 1; clr_if = 0; clr_mem = 0; dropped = 0;
    if_ar_valid = 0; mem_ar_valid = 0; if_flush = 0;
  endtask

  task automatic pin(input int k, input int s, input logic [63:0] v);
    pin_en[k] = 1'b1; pin_sel[k] = s; pin_val[k] = v;
  endtask

  // One clock: drive inputs for the new cycle and predict the outputs.
  task automatic step();
    @(posedge clk); #1;
    c++;
    for (int k = 0; k < 3; k++) pin_en[k] = 1'b0;
    if (clr_if) begin if_ar_valid = 0; clr_if = 0; end
    if (clr_mem) begin mem_ar_valid = 0; clr_mem = 0; end
    exp_if_rdy = 0; exp_mem_rdy = 0; exp_arv = 0; exp_rrdy = 0; exp_if_rv = 0; exp_mem_rv = 0;
    m_ar_ready = 0; m_r_valid = 0;
    m_r_data = {$urandom, $urandom}; m_r_resp = RW'($urandom_range(0, 3));
    if (reset) begin model_zero(); return; end
    if (rnd) begin
      if_flush = ($urandom_range(0, 5) == 0);
      if (!if_ar_valid) begin
        if ($urandom_range(0, 2) == 0) begin if_ar_valid = 1; if_ar_addr = {$urandom, $urandom}; end
      end else if (busy && $urandom_range(0, 9) == 0) if_ar_valid = 0;
      if (!mem_ar_valid) begin
        if ($urandom_range(0, 2) == 0) begin mem_ar_valid = 1; mem_ar_addr = {$urandom, $urandom}; end
      end else if (busy && $urandom_range(0, 9) == 0) mem_ar_valid = 0;
    end else begin
      if_flush = d_flush;
      if (d_if_new) begin if_ar_valid = 1; if_ar_addr = d_if_addr; d_if_new = 0; end
      if (d_mem_new) begin mem_ar_valid = 1; mem_ar_addr = d_mem_addr; d_mem_new = 0; end
    end
    if (busy && c == t_end) begin
      busy = 0;
      if (own_mem) begin
        exp_mem_rv = 1; exp_mem_data = pl_data; exp_mem_raddr = own_addr; exp_mem_resp = pl_resp;
      end else if (!dropped) begin
        exp_if_rv = 1; exp_if_data = pl_data; exp_if_raddr = own_addr; exp_if_resp = pl_resp;
      end
    end
    if (!busy) begin
      if (if_ar_valid || mem_ar_valid) begin
        win_mem = mem_ar_valid && (!if_ar_valid || ptr_mem);
        ptr_mem = !win_mem;
        own_mem = win_mem;
        own_addr = win_mem ? mem_ar_addr : if_ar_addr;
        exp_mem_rdy = win_mem; exp_if_rdy = !win_mem;
        clr_mem = win_mem; clr_if = !win_mem;
        if (rnd) begin
          aw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
          pl_data = {$urandom, $urandom}; pl_resp = RW'($urandom_range(0, 3));
        end else begin
          aw = d_a; rw = d_r; pl_data = d_data; pl_resp = d_resp;
        end
        t_g = c; t_end = c + 3 + aw + rw; busy = 1; dropped = 0;
      end
    end else begin
      if (if_flush && !own_mem) dropped = 1;
      if (c <= t_g + 1 + aw) begin
        exp_arv = 1; exp_araddr = own_addr; m_ar_ready = (c == t_g + 1 + aw);
      end else begin
        exp_rrdy = 1;
        if (c == t_end - 1) begin m_r_valid = 1; m_r_data = pl_data; m_r_resp = pl_resp; end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1; rnd = 0; d_flush = 0; d_if_new = 0; d_mem_new = 0;
    d_a = 0; d_r = 0; d_data = '0; d_resp = '0; d_if_addr = '0; d_mem_addr = '0;
    if_ar_addr = '0; mem_ar_addr = '0; m_ar_ready = 0; m_r_valid = 0;
    m_r_data = '0; m_r_resp = '0;
    for (int k = 0; k < 3; k++) begin pin_en[k] = 0; pin_sel[k] = 0; pin_val[k] = '0; end
    model_zero();
    chk_en = 1;
    step();
    step(); pin(0, 6, 64'h0); pin(1, 2, 64'h0); pin(2, 9, 64'h0);
    reset = 0;

    // Both requesters from reset: MEM first, then alternate
    d_if_addr = 64'h0000_0000_8000_0100; d_mem_addr = 64'h0000_0000_9000_0200;
    d_data = 64'hA5A5_0000_0000_0001; d_resp = 2'b00;
    d_if_new = 1; d_mem_new = 1;
    step(); pin(0, 1, 64'h1); pin(1, 0, 64'h0);
    run(2);
    step(); pin(0, 0, 64'h1); pin(1, 8, 64'h1); pin(2, 1, 64'h0);
    run(2);
    d_if_new = 1; d_mem_new = 1;
    step(); pin(0, 1, 64'h1); pin(1, 5, 64'h1); pin(2, 0, 64'h0);
    run(2);
    step(); pin(0, 0, 64'h1); pin(1, 8, 64'h1);
    run(3);

    // Single IF read with zero wait states
    d_if_addr = 64'h0000_0000_8000_0004; d_data = 64'h1122_3344_5566_7788; d_if_new = 1;
    step(); pin(0, 0, 64'h1);
    step(); pin(0, 2, 64'h1); pin(1, 3, 64'h0000_0000_8000_0004);
    step(); pin(0, 4, 64'h1);
    step(); pin(0, 5, 64'h1); pin(1, 6, 64'h1122_3344_5566_7788); pin(2, 7, 64'h0000_0000_8000_0004);

    // AR stalled 4 cycles, handshake on the 5th
    d_if_addr = 64'h0000_0000_8000_1000; d_a = 4; d_if_new = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      step(); pin(0, 2, 64'h1); pin(1, 3, 64'h0000_0000_8000_1000);
    end
    step(); pin(0, 4, 64'h1);
    step(); pin(0, 5, 64'h1);
    d_a = 0;

    // Flush while IF is in DATA drops the response
    d_if_addr = 64'h0000_0000_8000_2000; d_data = 64'hFFFF_0000_FFFF_0000; d_r = 2; d_if_new = 1;
    run(2);
    d_flush = 1;
    step(); pin(0, 4, 64'h1);
    d_flush = 0;
    step();
    step(); pin(0, 4, 64'h1);
    step(); pin(0, 5, 64'h0); pin(1, 4, 64'h0); pin(2, 7, 64'h0000_0000_8000_1000);
    d_r = 0;

    // MEM read with error response
    d_mem_addr = 64'h0000_0000_9000_0040; d_data = 64'h0BAD_0BAD_0BAD_0BAD; d_resp = 2'b10;
    d_a = 1; d_r = 1; d_mem_new = 1;
    run(5);
    step(); pin(0, 9, 64'h2); pin(1, 8, 64'h1);
    step(); pin(0, 8, 64'h0); pin(1, 9, 64'h2);
    d_a = 0; d_r = 0; d_resp = 2'b00;

    // Randomized traffic
    rnd = 1;
    run(1500);
    rnd = 0; d_flush = 0;
    for (int n = 0; n < 100 && (busy || if_ar_valid || mem_ar_valid || clr_if || clr_mem); n++) step();

    // Reset during the DATA beat abandons the transaction
    d_if_addr = 64'h0000_0000_8000_3000; d_data = 64'h7777_6666_5555_4444; d_if_new = 1;
    run(3);
    reset = 1;
    model_zero();
    mem_ar_valid = 1;
    pin(0, 4, 64'h0); pin(1, 2, 64'h0); pin(2, 1, 64'h0);
    step(); pin(0, 6, 64'h0); pin(1, 7, 64'h0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step(); pin(0, 5, 64'h0); pin(1, 8, 64'h0);
    end

    @(negedge clk); #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
YSYX_22041071_AXI_RD_ARB -- requirements
Module: ysyx_22041071_axi_rd_arb

Interface
REQ-001 Parameter: ADDR_W, default 64, address width of all address ports.
REQ-002 Parameter: DATA_W, default 64, read-data width.
REQ-003 Parameter: RESP_W, default 2, AXI response width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Ports, in the order name / direction / width / meaning:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- if_ar_valid  in  1  IF read request.
- if_ar_addr  in  ADDR_W  IF request address.
- if_ar_ready  out  1  IF request accepted, one-cycle pulse.
- if_flush  in  1  discard the outstanding IF response.
- if_r_valid  out  1  IF data valid, one-cycle pulse.
- if_r_data  out  DATA_W  IF read data.
- if_r_addr  out  ADDR_W  address of the returned IF data.
- if_r_resp  out  RESP_W  IF response code.
- mem_ar_valid / mem_ar_addr / mem_ar_ready  in / in / out  1 / ADDR_W / 1  MEM request, same rules as IF.
- mem_r_valid / mem_r_data / mem_r_addr / mem_r_resp  out  1 / DATA_W / ADDR_W / RESP_W  MEM response.
- m_ar_valid  out  1  AXI AR valid.
- m_ar_addr  out  ADDR_W  AXI AR address.
- m_ar_ready  in  1  AXI AR ready.
- m_r_valid  in  1  AXI R valid.
- m_r_data  in  DATA_W  AXI R data.
- m_r_resp  in  RESP_W  AXI R response.
- m_r_ready  out  1  AXI R ready.

Function
REQ-006 The block SHALL allow at most one outstanding AXI read and use a three-state FSM: IDLE, ADDR, DATA.
REQ-007 In IDLE, when any request is valid, the block SHALL grant one requester, pulse that requester's ar_ready for that cycle, latch its address and the owner ID, and move to ADDR on the next edge.
REQ-008 Arbitration SHALL be round-robin. If both requesters are valid, the grant goes to the one that did not win the previous grant. The priority pointer resets to MEM-first.
REQ-009 In ADDR, m_ar_valid SHALL be 1 and m_ar_addr SHALL equal the latched address. The address SHALL stay stable until m_ar_ready is sampled high, and the FSM then moves to DATA.
REQ-010 In DATA, m_r_ready SHALL be 1.
REQ-011 When m_r_valid is sampled high in DATA, the block SHALL register m_r_data and m_r_resp, pulse the owner's r_valid for exactly one cycle on the next cycle with r_addr equal to the latched address, and return to IDLE.
REQ-012 The minimum latency from request to r_valid SHALL be 3 cycles (grant, AR, R) plus AXI slave wait states.
REQ-013 r_data, r_addr and r_resp SHALL hold their last values until the next response to the same requester.
REQ-014 A sticky drop flag SHALL be set if if_flush is high while IF owns the transaction in ADDR or DATA.
REQ-015 When the drop flag is set, the IF response SHALL still complete on AXI but if_r_valid SHALL NOT pulse. The flag clears on the return to IDLE.
REQ-016 An if_flush in IDLE, or while MEM owns the transaction, SHALL have no effect.
REQ-017 A request whose valid deasserts before it is granted SHALL be ignored; no ar_ready pulse is issued for it.
REQ-018 A request arriving in ADDR or DATA SHALL wait. The grant for it may occur in the IDLE cycle that follows the response, so there is no dead cycle beyond that IDLE cycle.
REQ-019 A nonzero m_r_resp SHALL be forwarded unchanged. The block SHALL NOT retry.
REQ-020 The two r_valid outputs SHALL never be high in the same cycle.
REQ-021 The two ar_ready outputs SHALL never be high in the same cycle.

Reset
REQ-022 Reset SHALL act asynchronously. It forces the FSM to IDLE and sets m_ar_valid, m_r_ready, if_ar_ready, mem_ar_ready, if_r_valid, mem_r_valid and the drop flag to 0. It sets all data, address and resp outputs to 0 and the priority pointer to MEM.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; no response is forwarded after reset is released.

Verification
REQ-024 IF only, addr 0x8000_0004, m_ar_ready=1, R data 0x1122334455667788 one cycle later -> if_ar_ready pulse, then m_ar_addr=0x8000_0004, then if_r_valid=1 with data 0x1122334455667788 and if_r_addr=0x8000_0004.
REQ-025 IF and MEM both valid from reset -> MEM granted first, then IF. Repeated simultaneous requests alternate grants.
REQ-026 m_ar_ready held low 4 cycles -> m_ar_valid=1 with a stable address for all 4 cycles. The handshake occurs on the 5th cycle.
REQ-027 if_flush pulsed during IF DATA -> m_r_ready completes the beat, if_r_valid stays 0, and the FSM is back in IDLE on the next cycle.
REQ-028 MEM read returns m_r_resp=2'b10 -> mem_r_resp=2'b10 and mem_r_valid pulses once.
REQ-029 Reset asserted during DATA while m_r_valid arrives in the same cycle -> all outputs are 0 immediately and no r_valid pulses after release.
